// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags and sticky errors.
// Define FWFT_EN for first-word-fall-through reads; otherwise reads are registered.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wren,
    input  logic [DATA_W-1:0] wrdata,
    input  logic              rden,
    input  logic              err_clr,
    output logic [DATA_W-1:0] rddata,
    output logic              rdvalid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] C_AF    = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W:0] C_AE    = (ADDR_W + 1)'(AE_THRESH);
    localparam logic [ADDR_W:0] C_ONE   = (ADDR_W + 1)'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wrptr;
    logic [ADDR_W:0]   r_rdptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_full;
    logic              w_empty;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic [ADDR_W-1:0] w_wr_idx;
    logic [ADDR_W-1:0] w_rd_idx;

    // Requests are accepted only against the pre-edge occupancy: a write is taken
    // when wren & ~full, a read when rden & ~empty; rejected requests change nothing.
    assign w_full   = (r_count == C_DEPTH);
    assign w_empty  = (r_count == '0);
    assign w_wr_ok  = wren & ~w_full;
    assign w_rd_ok  = rden & ~w_empty;
    assign w_wr_idx = r_wrptr[ADDR_W-1:0];
    assign w_rd_idx = r_rdptr[ADDR_W-1:0];

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= C_AF);
    assign almost_empty = (r_count <= C_AE);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrptr <= '0;
            r_rdptr <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_ok) r_wrptr <= r_wrptr + C_ONE;
            if (w_rd_ok) r_rdptr <= r_rdptr + C_ONE;
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok && !rst) r_mem[w_wr_idx] <= wrdata;
    end

    // A fresh error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wren && w_full)      r_overflow <= 1'b1;
            else if (err_clr)        r_overflow <= 1'b0;
            if (rden && w_empty)     r_underflow <= 1'b1;
            else if (err_clr)        r_underflow <= 1'b0;
        end
    end

`ifdef FWFT_EN
    assign rddata  = r_mem[w_rd_idx];
    assign rdvalid = ~w_empty;
`else
    logic [DATA_W-1:0] r_rddata;
    logic              r_rdvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rddata  <= '0;
            r_rdvalid <= 1'b0;
        end else begin
            r_rdvalid <= w_rd_ok;
            if (w_rd_ok) r_rddata <= r_mem[w_rd_idx];
        end
    end

    assign rddata  = r_rddata;
    assign rdvalid = r_rdvalid;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param (DEPTH=4, AF=3, AE=1) with a queue-based reference model.
// Define FWFT_EN to exercise the fall-through build.
module tb_sync_fifo_param;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;
    localparam int AF_T   = 3;
    localparam int AE_T   = 1;

    logic              clk;
    logic              rst;
    logic              wren;
    logic [DATA_W-1:0] wrdata;
    logic              rden;
    logic              err_clr;
    logic [DATA_W-1:0] rddata;
    logic              rdvalid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    int n_checks;
    int n_errors;

    // Reference model state
    logic [DATA_W-1:0] exp_q[$];
    bit                m_ovf;
    bit                m_udf;
    bit                m_rdvalid;
    logic [DATA_W-1:0] m_rddata;

    sync_fifo_param #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .AF_THRESH(AF_T),
        .AE_THRESH(AE_T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wren        (wren),
        .wrdata      (wrdata),
        .rden        (rden),
        .err_clr     (err_clr),
        .rddata      (rddata),
        .rdvalid     (rdvalid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle of stimulus; model advances from its own pre-edge state.
    task automatic apply(input bit r, input bit w, input logic [DATA_W-1:0] d,
                         input bit rd, input bit c);
        bit was_full;
        bit was_empty;
        rst = r; wren = w; wrdata = d; rden = rd; err_clr = c;
        @(posedge clk);
        was_full  = (exp_q.size() == DEPTH);
        was_empty = (exp_q.size() == 0);
        if (r) begin
            exp_q.delete();
            m_ovf = 0; m_udf = 0; m_rdvalid = 0; m_rddata = '0;
        end else begin
            m_rdvalid = rd && !was_empty;
            if (rd && !was_empty) m_rddata = exp_q.pop_front();
            if (w && !was_full) exp_q.push_back(d);
            if (w && was_full) m_ovf = 1; else if (c) m_ovf = 0;
            if (rd && was_empty) m_udf = 1; else if (c) m_udf = 0;
        end
        #1;
        rst = 0; wren = 0; rden = 0; err_clr = 0;
    endtask

    task automatic test_reset();
        apply(1, 0, 8'h00, 0, 0);
        apply(1, 0, 8'h00, 0, 0);
        n_checks += 8;
        if (count !== 3'd0)       begin n_errors++; $display("FAIL reset_count got %0d want 0", count); end
        if (empty !== 1'b1)       begin n_errors++; $display("FAIL reset_empty got %b want 1", empty); end
        if (almost_empty !== 1'b1) begin n_errors++; $display("FAIL reset_ae got %b want 1", almost_empty); end
        if (full !== 1'b0)        begin n_errors++; $display("FAIL reset_full got %b want 0", full); end
        if (almost_full !== 1'b0) begin n_errors++; $display("FAIL reset_af got %b want 0", almost_full); end
        if (overflow !== 1'b0)    begin n_errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
        if (underflow !== 1'b0)   begin n_errors++; $display("FAIL reset_udf got %b want 0", underflow); end
        if (rdvalid !== 1'b0)     begin n_errors++; $display("FAIL reset_rdvalid got %b want 0", rdvalid); end
`ifndef FWFT_EN
        n_checks++;
        if (rddata !== 8'h00)     begin n_errors++; $display("FAIL reset_rddata got %h want 00", rddata); end
`endif
    endtask

    task automatic test_fill_overflow();
        logic [DATA_W-1:0] vals[4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            apply(0, 1, vals[i], 0, 0);
            n_checks += 4;
            if (count !== 3'(i + 1)) begin n_errors++; $display("FAIL fill_count got %0d want %0d", count, i + 1); end
            if (almost_empty !== (i + 1 <= AE_T)) begin n_errors++; $display("FAIL fill_ae got %b at count %0d", almost_empty, i + 1); end
            if (almost_full !== (i + 1 >= AF_T))  begin n_errors++; $display("FAIL fill_af got %b at count %0d", almost_full, i + 1); end
            if (full !== (i + 1 == DEPTH))        begin n_errors++; $display("FAIL fill_full got %b at count %0d", full, i + 1); end
        end
        apply(0, 1, 8'h55, 0, 0);
        n_checks += 2;
        if (count !== 3'd4)    begin n_errors++; $display("FAIL ovf_count got %0d want 4", count); end
        if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_set got %b want 1", overflow); end
        apply(0, 0, 8'h00, 0, 0);
        n_checks++;
        if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        apply(0, 0, 8'h00, 0, 1);
        n_checks++;
        if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_clr got %b want 0", overflow); end
    endtask

    task automatic test_drain_underflow();
        logic [DATA_W-1:0] vals[4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
`ifdef FWFT_EN
            n_checks++;
            if (rddata !== vals[i]) begin n_errors++; $display("FAIL drain_head got %h want %h", rddata, vals[i]); end
            apply(0, 0, 8'h00, 1, 0);
`else
            apply(0, 0, 8'h00, 1, 0);
            n_checks += 2;
            if (rddata !== vals[i]) begin n_errors++; $display("FAIL drain_data got %h want %h", rddata, vals[i]); end
            if (rdvalid !== 1'b1)   begin n_errors++; $display("FAIL drain_valid got %b want 1", rdvalid); end
`endif
        end
        n_checks++;
        if (empty !== 1'b1) begin n_errors++; $display("FAIL drain_empty got %b want 1", empty); end
        apply(0, 0, 8'h00, 1, 0);
        n_checks += 2;
        if (rdvalid !== 1'b0)   begin n_errors++; $display("FAIL udf_valid got %b want 0", rdvalid); end
        if (underflow !== 1'b1) begin n_errors++; $display("FAIL udf_set got %b want 1", underflow); end
`ifndef FWFT_EN
        n_checks++;
        if (rddata !== 8'h44)   begin n_errors++; $display("FAIL udf_hold got %h want 44", rddata); end
`endif
        apply(0, 0, 8'h00, 0, 1);
        n_checks++;
        if (underflow !== 1'b0) begin n_errors++; $display("FAIL udf_clr got %b want 0", underflow); end
    endtask

    task automatic test_simultaneous();
        apply(0, 1, 8'h01, 0, 0);
        apply(0, 1, 8'h02, 0, 0);
        apply(0, 1, 8'h03, 1, 0);
        n_checks++;
        if (count !== 3'd2) begin n_errors++; $display("FAIL both_mid_count got %0d want 2", count); end
`ifndef FWFT_EN
        n_checks++;
        if (rddata !== 8'h01) begin n_errors++; $display("FAIL both_mid_data got %h want 01", rddata); end
`endif
        for (int i = 0; i < 2; i++) begin
`ifdef FWFT_EN
            n_checks++;
            if (rddata !== 8'(i + 2)) begin n_errors++; $display("FAIL both_order got %h want %h", rddata, 8'(i + 2)); end
            apply(0, 0, 8'h00, 1, 0);
`else
            apply(0, 0, 8'h00, 1, 0);
            n_checks++;
            if (rddata !== 8'(i + 2)) begin n_errors++; $display("FAIL both_order got %h want %h", rddata, 8'(i + 2)); end
`endif
        end
        for (int i = 0; i < 4; i++) apply(0, 1, 8'(8'hC0 + i), 0, 0);
        apply(0, 1, 8'hCF, 1, 0);
        n_checks += 2;
        if (count !== 3'd3)    begin n_errors++; $display("FAIL both_full_count got %0d want 3", count); end
        if (overflow !== 1'b1) begin n_errors++; $display("FAIL both_full_ovf got %b want 1", overflow); end
        for (int i = 0; i < 3; i++) apply(0, 0, 8'h00, 1, 0);
        apply(0, 1, 8'hE1, 1, 1);
        n_checks += 3;
        if (count !== 3'd1)     begin n_errors++; $display("FAIL both_empty_count got %0d want 1", count); end
        if (underflow !== 1'b1) begin n_errors++; $display("FAIL both_empty_udf got %b want 1", underflow); end
        if (overflow !== 1'b0)  begin n_errors++; $display("FAIL both_empty_ovfclr got %b want 0", overflow); end
        apply(0, 0, 8'h00, 1, 1);
    endtask

    task automatic test_wrap();
        int next_exp;
        next_exp = 1;
        apply(0, 1, 8'h01, 0, 0);
        for (int v = 2; v <= 11; v++) begin
`ifdef FWFT_EN
            n_checks++;
            if (rddata !== 8'(next_exp)) begin n_errors++; $display("FAIL wrap_data got %h want %h", rddata, 8'(next_exp)); end
            next_exp++;
`endif
            apply(0, v <= 10, 8'(v), 1, 0);
`ifndef FWFT_EN
            n_checks += 2;
            if (rddata !== 8'(next_exp)) begin n_errors++; $display("FAIL wrap_data got %h want %h", rddata, 8'(next_exp)); end
            if (rdvalid !== 1'b1)        begin n_errors++; $display("FAIL wrap_valid got %b want 1", rdvalid); end
            next_exp++;
`endif
            n_checks += 3;
            if (count !== 3'(exp_q.size())) begin n_errors++; $display("FAIL wrap_count got %0d want %0d", count, exp_q.size()); end
            if (full !== 1'b0 || almost_full !== 1'b0) begin n_errors++; $display("FAIL wrap_fullflags got %b%b want 00", full, almost_full); end
            if (almost_empty !== 1'b1) begin n_errors++; $display("FAIL wrap_ae got %b want 1", almost_empty); end
        end
        n_checks++;
        if (next_exp !== 11 || empty !== 1'b1) begin n_errors++; $display("FAIL wrap_end got next=%0d empty=%b want 11 1", next_exp, empty); end
    endtask

    task automatic test_reset_mid();
        apply(0, 1, 8'h31, 0, 0);
        apply(0, 1, 8'h32, 0, 0);
        apply(0, 1, 8'h33, 0, 0);
        apply(0, 1, 8'h00, 1, 0);
        apply(0, 0, 8'h00, 1, 0);
        apply(1, 0, 8'h00, 1, 0);
        n_checks += 5;
        if (count !== 3'd0)        begin n_errors++; $display("FAIL rstmid_count got %0d want 0", count); end
        if (empty !== 1'b1)        begin n_errors++; $display("FAIL rstmid_empty got %b want 1", empty); end
        if (almost_empty !== 1'b1) begin n_errors++; $display("FAIL rstmid_ae got %b want 1", almost_empty); end
        if (rdvalid !== 1'b0)      begin n_errors++; $display("FAIL rstmid_valid got %b want 0", rdvalid); end
        if (overflow !== 1'b0 || underflow !== 1'b0) begin n_errors++; $display("FAIL rstmid_err got %b%b want 00", overflow, underflow); end
        apply(0, 1, 8'h77, 0, 0);
`ifdef FWFT_EN
        n_checks++;
        if (rddata !== 8'h77) begin n_errors++; $display("FAIL rstmid_data got %h want 77", rddata); end
        apply(0, 0, 8'h00, 1, 0);
`else
        apply(0, 0, 8'h00, 1, 0);
        n_checks++;
        if (rddata !== 8'h77) begin n_errors++; $display("FAIL rstmid_data got %h want 77", rddata); end
`endif
    endtask

    task automatic test_fwft();
`ifdef FWFT_EN
        apply(0, 1, 8'hA5, 0, 0);
        n_checks += 2;
        if (rddata !== 8'hA5) begin n_errors++; $display("FAIL fwft_head got %h want a5", rddata); end
        if (rdvalid !== 1'b1) begin n_errors++; $display("FAIL fwft_valid got %b want 1", rdvalid); end
        apply(0, 0, 8'h00, 1, 0);
        n_checks += 2;
        if (empty !== 1'b1)   begin n_errors++; $display("FAIL fwft_empty got %b want 1", empty); end
        if (rdvalid !== 1'b0) begin n_errors++; $display("FAIL fwft_novalid got %b want 0", rdvalid); end
`endif
    endtask

    task automatic test_random();
        int sz;
        for (int n = 0; n < 400; n++) begin
            apply($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
            sz = exp_q.size();
            n_checks += 8;
            if (count !== 3'(sz))                begin n_errors++; $display("FAIL rnd_count got %0d want %0d", count, sz); end
            if (full !== (sz == DEPTH))          begin n_errors++; $display("FAIL rnd_full got %b size %0d", full, sz); end
            if (empty !== (sz == 0))             begin n_errors++; $display("FAIL rnd_empty got %b size %0d", empty, sz); end
            if (almost_full !== (sz >= AF_T))    begin n_errors++; $display("FAIL rnd_af got %b size %0d", almost_full, sz); end
            if (almost_empty !== (sz <= AE_T))   begin n_errors++; $display("FAIL rnd_ae got %b size %0d", almost_empty, sz); end
            if (overflow !== m_ovf)              begin n_errors++; $display("FAIL rnd_ovf got %b want %b", overflow, m_ovf); end
            if (underflow !== m_udf)             begin n_errors++; $display("FAIL rnd_udf got %b want %b", underflow, m_udf); end
`ifdef FWFT_EN
            if (rdvalid !== (sz != 0))           begin n_errors++; $display("FAIL rnd_valid got %b want %b", rdvalid, sz != 0); end
            if (sz != 0) begin
                n_checks++;
                if (rddata !== exp_q[0])         begin n_errors++; $display("FAIL rnd_data got %h want %h", rddata, exp_q[0]); end
            end
`else
            if (rdvalid !== m_rdvalid)           begin n_errors++; $display("FAIL rnd_valid got %b want %b", rdvalid, m_rdvalid); end
            n_checks++;
            if (rddata !== m_rddata)             begin n_errors++; $display("FAIL rnd_data got %h want %h", rddata, m_rddata); end
`endif
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst = 1; wren = 0; wrdata = '0; rden = 0; err_clr = 0;
        m_ovf = 0; m_udf = 0; m_rdvalid = 0; m_rddata = '0;
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        test_fwft();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
